// File: rtl/pong_game_ctrl_if.sv
// Pong controller port bundle: game events in, timing strobes and score state out.
interface pong_game_ctrl_if;
  logic       key_start;
  logic       hit_bottom;
  logic       hit_top;
  logic       miss_bottom;
  logic       miss_top;
  logic       move_en;
  logic       ball_load;
  logic       serve_down;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [2:0] speed_lvl;
  logic [2:0] state;
  logic       game_over;
  logic       winner;

  modport master (
    output key_start, hit_bottom, hit_top, miss_bottom, miss_top,
    input  move_en, ball_load, serve_down, score1, score2, speed_lvl,
           state, game_over, winner
  );

  modport slave (
    input  key_start, hit_bottom, hit_top, miss_bottom, miss_top,
    output move_en, ball_load, serve_down, score1, score2, speed_lvl,
           state, game_over, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve delay, speed-scaled move strobe, scoring, game over.
module pong_game_ctrl #(
  parameter int T_BASE         = 500_000,
  parameter int T_STEP         = 50_000,
  parameter int T_MIN          = 200_000,
  parameter int LVL_MAX        = 6,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SERVE_TICKS    = 100,
  parameter int WIN_SCORE      = 7
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } st_e;

  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [19:0]   TB_LAST  = 20'(T_BASE - 1);
  localparam logic [SW-1:0] SV_LAST  = SW'(SERVE_TICKS - 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(HITS_PER_LEVEL - 1);
  localparam logic [2:0]    LVL_TOP  = 3'(LVL_MAX);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  st_e           st, st_n;
  logic [19:0]   cnt, cnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [HW-1:0] hit, hit_n;
  logic [2:0]    spd, spd_n;
  logic [3:0]    s1, s1_n, s2, s2_n;
  logic          sdown, sdown_n, bl, bl_n, win, win_n;
  logic [31:0]   red;
  logic [19:0]   period;
  logic          move;

  // PLAY period, floored at T_MIN; the subtraction is guarded so it never wraps
  always_comb begin
    red = 32'(spd) * 32'(T_STEP);
    if (32'(T_BASE) > red && (32'(T_BASE) - red) > 32'(T_MIN))
      period = 20'(32'(T_BASE) - red);
    else
      period = 20'(T_MIN);
  end

  // >= rather than == so a shortened period fires at once instead of overrunning
  assign move = (st == PLAY) && (cnt >= period - 20'd1);

  // next-state and datapath updates
  always_comb begin
    st_n = st; cnt_n = cnt; scnt_n = scnt; hit_n = hit; spd_n = spd;
    s1_n = s1; s2_n = s2; sdown_n = sdown; bl_n = 1'b0; win_n = win;
    case (st)
      IDLE, OVER: begin
        cnt_n = '0;
        if (bus.key_start) begin
          s1_n = '0; s2_n = '0; spd_n = '0; hit_n = '0; scnt_n = '0;
          sdown_n = 1'b1; bl_n = 1'b1; st_n = SERVE;
        end
      end
      SERVE: begin
        if (cnt >= TB_LAST) begin
          cnt_n = '0;
          if (scnt == SV_LAST) begin
            scnt_n = '0; st_n = PLAY;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end else begin
          cnt_n = cnt + 20'd1;
        end
      end
      PLAY: begin
        cnt_n = move ? 20'd0 : cnt + 20'd1;
        if (bus.miss_bottom || bus.miss_top) begin
          st_n = POINT; cnt_n = '0;
          if (bus.miss_bottom && !bus.miss_top) begin
            s2_n = s2 + 4'd1; sdown_n = 1'b1;
          end else if (bus.miss_top && !bus.miss_bottom) begin
            s1_n = s1 + 4'd1; sdown_n = 1'b0;
          end
        end else if (bus.hit_bottom || bus.hit_top) begin
          if (hit == HIT_LAST) begin
            hit_n = '0;
            if (spd < LVL_TOP) spd_n = spd + 3'd1;
          end else begin
            hit_n = hit + HW'(1);
          end
        end
      end
      POINT: begin
        cnt_n = '0;
        if (s1 == WIN || s2 == WIN) begin
          st_n = OVER; win_n = (s2 == WIN);
        end else begin
          st_n = SERVE; spd_n = '0; hit_n = '0; scnt_n = '0; bl_n = 1'b1;
        end
      end
      default: begin
        st_n = IDLE; cnt_n = '0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE; cnt <= '0; scnt <= '0; hit <= '0; spd <= '0;
      s1 <= '0; s2 <= '0; sdown <= 1'b1; bl <= 1'b0; win <= 1'b0;
    end else begin
      st <= st_n; cnt <= cnt_n; scnt <= scnt_n; hit <= hit_n; spd <= spd_n;
      s1 <= s1_n; s2 <= s2_n; sdown <= sdown_n; bl <= bl_n; win <= win_n;
    end
  end

  assign bus.move_en    = move;
  assign bus.ball_load  = bl;
  assign bus.serve_down = sdown;
  assign bus.score1     = s1;
  assign bus.score2     = s2;
  assign bus.speed_lvl  = spd;
  assign bus.state      = st;
  assign bus.game_over  = (st == OVER);
  assign bus.winner     = win;
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter T_BASE, default 500_000, PLAY move period in clocks at speed level 0 (10 ms at 50 MHz).
REQ-002 SHALL have parameter T_STEP, default 50_000, period reduction per speed level.
REQ-003 SHALL have parameter T_MIN, default 200_000, floor on the move period.
REQ-004 SHALL have parameter LVL_MAX, default 6, saturation value of speed_lvl.
REQ-005 SHALL have parameter HITS_PER_LEVEL, default 4, paddle hits per speed-level increment.
REQ-006 SHALL have parameter SERVE_TICKS, default 100, number of T_BASE periods in the serve delay.
REQ-007 SHALL have parameter WIN_SCORE, default 7 (legal range 1..15), points needed to win.
REQ-008 SHALL have clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-009 SHALL have rst, input, 1, reset that is synchronous and active-high.
REQ-010 SHALL have key_start, input, 1, single-cycle start pulse from the key debouncer.
REQ-011 SHALL have hit_bottom and hit_top, inputs, 1 each, single-cycle pulses when the bottom or top paddle returns the ball.
REQ-012 SHALL have miss_bottom and miss_top, inputs, 1 each, single-cycle pulses when the ball passes the bottom or top paddle.
REQ-013 SHALL have move_en, output, 1, one-cycle ball/paddle step strobe.
REQ-014 SHALL have ball_load, output, 1, one-cycle strobe that reloads the ball start position.
REQ-015 SHALL have serve_down, output, 1, initial ball y-direction: 1 = toward the bottom paddle.
REQ-016 SHALL have score1 and score2, outputs, 4 each; score1 belongs to the bottom player and score2 to the top player.
REQ-017 SHALL have speed_lvl, output, 3, current speed level.
REQ-018 SHALL have state, output, 3, encoded IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-019 SHALL have game_over, output, 1, high while in OVER; and winner, output, 1, 0 = bottom player, 1 = top player.

Function
REQ-020 Period counter SHALL be 20 bits; the PLAY period SHALL be P = max(T_BASE - speed_lvl*T_STEP, T_MIN), computed without underflow.
REQ-021 In PLAY the counter SHALL count 0..P-1, assert move_en for exactly the cycle where cnt==P-1, then return to 0.
REQ-022 In IDLE, POINT and OVER the counter SHALL be held at 0 and move_en SHALL be 0.
REQ-023 In IDLE, key_start SHALL do all of the following: clear the scores, speed_lvl and hit count; set serve_down=1; assert ball_load on the next cycle; and move to SERVE.
REQ-024 In SERVE the counter SHALL run with period T_BASE and move_en SHALL remain 0.
REQ-025 In SERVE each counter wrap SHALL increment the serve count; on the SERVE_TICKS-th wrap the state SHALL go to PLAY with the counter cleared.
REQ-026 ball_load SHALL be high exactly on the first cycle of every SERVE entry and low at all other times.
REQ-027 In PLAY, miss_bottom alone SHALL increment score2, set serve_down=1 and move to POINT.
REQ-028 In PLAY, miss_top alone SHALL increment score1, set serve_down=0 and move to POINT.
REQ-029 In PLAY, miss_bottom and miss_top in the same cycle SHALL award no point, leave serve_down unchanged and move to POINT.
REQ-030 In PLAY, hit_bottom or hit_top (or both, counted as one) SHALL increment the hit count, unless the same cycle carries a miss, in which case the hit is ignored.
REQ-031 When the hit count reaches HITS_PER_LEVEL, the hit count SHALL clear and speed_lvl SHALL increment, saturating at LVL_MAX.
REQ-032 A period change SHALL take effect from the next counter restart; a running count SHALL not be truncated, except when cnt is already >= new P-1, in which case the next cycle SHALL assert move_en and wrap.
REQ-033 POINT SHALL last exactly 1 cycle.
REQ-034 On leaving POINT, if score1 or score2 equals WIN_SCORE the state SHALL go to OVER, set game_over=1 and set winner to the scoring player.
REQ-035 On leaving POINT when no player has reached WIN_SCORE, the state SHALL go to SERVE, clear speed_lvl and the hit count, and assert ball_load.
REQ-036 In OVER the scores and winner SHALL be held.
REQ-037 In OVER, key_start SHALL behave exactly as in IDLE (new game, game_over cleared).
REQ-038 key_start SHALL be ignored in SERVE, PLAY and POINT; hit and miss pulses SHALL be ignored outside PLAY.
REQ-039 An undefined state encoding SHALL recover to IDLE on the next cycle.

Reset
REQ-040 rst high at a clock edge SHALL, from any state including mid-count, produce on that edge: state=IDLE, counters=0, score1=score2=0, speed_lvl=0, move_en=0, ball_load=0, serve_down=1, game_over=0, winner=0.
REQ-041 rst SHALL take priority over every other input in the same cycle.

Verification (params T_BASE=10, T_STEP=2, T_MIN=4, LVL_MAX=6, HITS_PER_LEVEL=2, SERVE_TICKS=3, WIN_SCORE=3)
REQ-042 key_start in IDLE -> ball_load pulses once; state=SERVE for 30 cycles; then PLAY; first move_en 10 cycles later and every 10 cycles after that.
REQ-043 2 hit pulses in PLAY -> speed_lvl=1 and move_en period 8; after 8 hits total -> speed_lvl=4 and period 4 (floored at T_MIN, not 2).
REQ-044 miss_bottom in PLAY -> score2=1, serve_down=1, one POINT cycle, SERVE with ball_load, speed_lvl back to 0.
REQ-045 miss_top and miss_bottom together, plus hit_top, in the same cycle -> scores unchanged, hit count unchanged, POINT then SERVE.
REQ-046 Bottom player scores 3 times -> OVER, game_over=1, winner=0; key_start then restarts with scores 0 and state SERVE.
REQ-047 rst asserted mid-PLAY with cnt=5, speed_lvl=2, score1=2 -> next cycle all REQ-040 values hold and key_start is required to resume.
